// File: rtl/hc16x_counter.sv
`timescale 1ns/1ps
// hc16x_counter: parametrised modulo-N up/down counter keeping the 74HC161
// CEP/CET/PEN control set, with a cascadable TC and a sticky wrap flag OVF.
module hc16x_counter #(
  parameter int     WIDTH       = 4,
  parameter longint MODULUS     = 16,
  parameter longint RESET_VALUE = 0
) (
  input  logic             CP,
  input  logic             MR,
  input  logic             CEP,
  input  logic             CET,
  input  logic             PEN,
  input  logic             UP,
  input  logic [WIDTH-1:0] Dn,
  input  logic             OVF_CLR,
  output logic [WIDTH-1:0] Qn,
  output logic             TC,
  output logic             OVF
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] ZERO    = '0;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("hc16x_counter: WIDTH=%0d outside 2..32", WIDTH);
  end
  if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
    $error("hc16x_counter: MODULUS=%0d outside 2..2**WIDTH", MODULUS);
  end
  if (RESET_VALUE < 0 || RESET_VALUE >= MODULUS) begin : g_bad_reset
    $error("hc16x_counter: RESET_VALUE=%0d not below MODULUS", RESET_VALUE);
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] loadVal;
  logic             atTerminal;
  logic             countEn;
  logic             wrap;

  // A full binary modulus can never see an out-of-range load, so no clamp.
  if (MODULUS == (longint'(1) << WIDTH)) begin : g_no_clamp
    assign loadVal = Dn;
  end else begin : g_clamp
    assign loadVal = (Dn > MAX_VAL) ? MAX_VAL : Dn;
  end

  assign atTerminal = UP ? (count_q == MAX_VAL) : (count_q == ZERO);
  assign countEn    = CEP & CET;

  // Load beats count; a wrap sets OVF and beats a same-edge clear.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    wrap    = 1'b0;
    if (!PEN) begin
      count_d = loadVal;
    end else if (countEn) begin
      wrap = atTerminal;
      if (UP) begin
        count_d = atTerminal ? ZERO : count_q + ONE;
      end else begin
        count_d = atTerminal ? MAX_VAL : count_q - ONE;
      end
    end
    if (wrap) begin
      ovf_d = 1'b1;
    end else if (OVF_CLR) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge CP) begin
    if (MR) begin
      count_q <= RST_VAL;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Qn  = count_q;
  assign OVF = ovf_q;
  assign TC  = CET & atTerminal;

endmodule

// File: tb/tb_hc16x_counter.sv
`timescale 1ns/1ps
// tb_hc16x_counter: directed and randomized checks of three counter variants
// plus a two-stage cascade, against a modular-arithmetic reference model.
module tb_hc16x_counter;

  logic CP = 1'b0;
  always #5 CP = ~CP;

  // Index 0: 4-bit mod 16, index 1: 4-bit mod 10, index 2: 8-bit mod 200 reset 5.
  logic [2:0] mr, pen, cep, cet, up, clr;
  logic [3:0] dnA, dnB;
  logic [7:0] dnR;
  logic [3:0] qA, qB;
  logic [7:0] qR;
  logic [2:0] tc, ovf;

  logic       cMr;
  logic [3:0] cq0, cq1;
  logic       tc0, tc1, ovf0, ovf1;

  hc16x_counter #(.WIDTH(4), .MODULUS(16), .RESET_VALUE(0)) dutA (
    .CP(CP), .MR(mr[0]), .CEP(cep[0]), .CET(cet[0]), .PEN(pen[0]), .UP(up[0]),
    .Dn(dnA), .OVF_CLR(clr[0]), .Qn(qA), .TC(tc[0]), .OVF(ovf[0]));

  hc16x_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) dutB (
    .CP(CP), .MR(mr[1]), .CEP(cep[1]), .CET(cet[1]), .PEN(pen[1]), .UP(up[1]),
    .Dn(dnB), .OVF_CLR(clr[1]), .Qn(qB), .TC(tc[1]), .OVF(ovf[1]));

  hc16x_counter #(.WIDTH(8), .MODULUS(200), .RESET_VALUE(5)) dutR (
    .CP(CP), .MR(mr[2]), .CEP(cep[2]), .CET(cet[2]), .PEN(pen[2]), .UP(up[2]),
    .Dn(dnR), .OVF_CLR(clr[2]), .Qn(qR), .TC(tc[2]), .OVF(ovf[2]));

  hc16x_counter #(.WIDTH(4), .MODULUS(16), .RESET_VALUE(0)) casc0 (
    .CP(CP), .MR(cMr), .CEP(1'b1), .CET(1'b1), .PEN(1'b1), .UP(1'b1),
    .Dn(4'd0), .OVF_CLR(1'b0), .Qn(cq0), .TC(tc0), .OVF(ovf0));

  hc16x_counter #(.WIDTH(4), .MODULUS(16), .RESET_VALUE(0)) casc1 (
    .CP(CP), .MR(cMr), .CEP(1'b1), .CET(tc0), .PEN(1'b1), .UP(1'b1),
    .Dn(4'd0), .OVF_CLR(1'b0), .Qn(cq1), .TC(tc1), .OVF(ovf1));

  int total = 0;
  int bad   = 0;

  longint MODS [3] = '{16, 10, 200};
  longint RVS  [3] = '{0, 0, 5};
  longint mq   [3] = '{0, 0, 0};
  bit     movf [3] = '{0, 0, 0};
  longint dnv  [3] = '{0, 0, 0};
  bit     primed   = 1'b0;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] getQ(input int i);
    case (i)
      0:       return 64'(qA);
      1:       return 64'(qB);
      default: return 64'(qR);
    endcase
  endfunction

  task automatic applyStimulus(input int i, input bit m, input bit p, input bit ce,
                               input bit ct, input bit u, input bit c, input logic [7:0] d);
    mr[i]  = m;
    pen[i] = p;
    cep[i] = ce;
    cet[i] = ct;
    up[i]  = u;
    clr[i] = c;
    case (i)
      0:       begin dnA = d[3:0]; dnv[i] = longint'(d[3:0]); end
      1:       begin dnB = d[3:0]; dnv[i] = longint'(d[3:0]); end
      default: begin dnR = d;      dnv[i] = longint'(d);      end
    endcase
  endtask

  // One clock edge: check TC against the current inputs, advance the model, check Qn/OVF.
  task automatic checkOutput();
    longint nq [3];
    bit     nov[3];
    bit     wrap;
    bit     expTc;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (primed) begin
        expTc = cet[i] && (up[i] ? (mq[i] == MODS[i] - 1) : (mq[i] == 0));
        checkVal($sformatf("tc%0d", i), 64'(tc[i]), 64'(expTc));
      end
      wrap = 1'b0;
      if (mr[i]) begin
        nq[i]  = RVS[i];
        nov[i] = 1'b0;
      end else begin
        if (!pen[i]) begin
          nq[i] = (dnv[i] < MODS[i]) ? dnv[i] : MODS[i] - 1;
        end else if (cep[i] && cet[i]) begin
          if (up[i]) begin
            nq[i] = (mq[i] + 1) % MODS[i];
            wrap  = (mq[i] + 1 == MODS[i]);
          end else begin
            nq[i] = (mq[i] + MODS[i] - 1) % MODS[i];
            wrap  = (mq[i] == 0);
          end
        end else begin
          nq[i] = mq[i];
        end
        nov[i] = wrap ? 1'b1 : (clr[i] ? 1'b0 : movf[i]);
      end
    end
    @(posedge CP);
    #1;
    for (int i = 0; i < 3; i++) begin
      mq[i]   = nq[i];
      movf[i] = nov[i];
      checkVal($sformatf("q%0d", i), getQ(i), 64'(mq[i]));
      checkVal($sformatf("ovf%0d", i), 64'(ovf[i]), 64'(movf[i]));
    end
    primed = 1'b1;
  endtask

  initial begin
    cMr = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(i, 1, 1, 1, 1, 1, 0, 8'd0);
    checkOutput();
    checkVal("rst_qA", 64'(qA), 64'd0);
    checkVal("rst_ovfA", 64'(ovf[0]), 64'd0);
    checkVal("rst_qR", 64'(qR), 64'd5);

    // Plain up count on mod 16, down count on mod 10, variant R idle.
    applyStimulus(0, 0, 1, 1, 1, 1, 0, 8'd0);
    applyStimulus(1, 0, 1, 1, 1, 0, 0, 8'd0);
    applyStimulus(2, 0, 1, 0, 1, 1, 0, 8'd0);
    #1;
    checkVal("rst_tcA", 64'(tc[0]), 64'd0);
    checkVal("down_tcB_at0", 64'(tc[1]), 64'd1);
    for (int k = 1; k <= 17; k++) begin
      checkOutput();
      checkVal($sformatf("up_qA_%0d", k), 64'(qA), 64'(k % 16));
      checkVal($sformatf("up_ovfA_%0d", k), 64'(ovf[0]), 64'(k >= 16));
      checkVal($sformatf("dn_qB_%0d", k), 64'(qB), 64'((10 - k % 10) % 10));
      checkVal($sformatf("dn_ovfB_%0d", k), 64'(ovf[1]), 64'd1);
    end

    // Load clamp on mod 10 leaves OVF alone.
    applyStimulus(1, 0, 0, 1, 1, 0, 0, 8'd13);
    checkOutput();
    checkVal("clamp_qB", 64'(qB), 64'd9);
    checkVal("clamp_ovfB", 64'(ovf[1]), 64'd1);

    // Enables at Qn=15.
    applyStimulus(0, 0, 0, 1, 1, 1, 0, 8'd15);
    checkOutput();
    applyStimulus(0, 0, 1, 0, 1, 1, 0, 8'd0);
    #1;
    checkVal("cep0_tc", 64'(tc[0]), 64'd1);
    checkOutput();
    checkVal("cep0_hold", 64'(qA), 64'd15);
    applyStimulus(0, 0, 1, 1, 0, 1, 0, 8'd0);
    #1;
    checkVal("cet0_tc", 64'(tc[0]), 64'd0);
    checkOutput();
    checkVal("cet0_hold", 64'(qA), 64'd15);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 8'd6);
    checkOutput();
    checkVal("load_noen", 64'(qA), 64'd6);

    // Reset beats load and a wrapping count.
    applyStimulus(0, 0, 0, 1, 1, 1, 0, 8'd15);
    checkOutput();
    applyStimulus(0, 1, 0, 1, 1, 1, 0, 8'd7);
    checkOutput();
    checkVal("mr_win_q", 64'(qA), 64'd0);
    checkVal("mr_win_ovf", 64'(ovf[0]), 64'd0);

    // Wrap beats clear; clear alone drops OVF.
    applyStimulus(0, 0, 0, 1, 1, 1, 0, 8'd15);
    checkOutput();
    applyStimulus(0, 0, 1, 1, 1, 1, 1, 8'd0);
    checkOutput();
    checkVal("wrapclr_q", 64'(qA), 64'd0);
    checkVal("wrapclr_ovf", 64'(ovf[0]), 64'd1);
    checkOutput();
    checkVal("clr_q", 64'(qA), 64'd1);
    checkVal("clr_ovf", 64'(ovf[0]), 64'd0);

    // Direction reversal on the same edge.
    applyStimulus(0, 0, 0, 1, 1, 1, 0, 8'd4);
    checkOutput();
    applyStimulus(0, 0, 1, 1, 1, 1, 0, 8'd0);
    checkOutput();
    checkVal("rev_up", 64'(qA), 64'd5);
    applyStimulus(0, 0, 1, 1, 1, 0, 0, 8'd0);
    checkOutput();
    checkVal("rev_down", 64'(qA), 64'd4);

    // Two-stage cascade through TC0 -> CET1.
    for (int i = 0; i < 3; i++) applyStimulus(i, 0, 1, 0, 1, 1, 0, 8'd0);
    cMr = 1'b0;
    for (int k = 1; k <= 256; k++) begin
      checkOutput();
      checkVal($sformatf("casc_q_%0d", k), 64'({cq1, cq0}), 64'(k % 256));
      checkVal($sformatf("casc_ovf1_%0d", k), 64'(ovf1), 64'(k == 256));
      checkVal($sformatf("casc_ovf0_%0d", k), 64'(ovf0), 64'(k >= 16));
      checkVal($sformatf("casc_tc1_%0d", k), 64'(tc1), 64'(k == 255));
    end

    // Randomized traffic on all three variants.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++) begin
        applyStimulus(i,
                      $urandom_range(0, 31) == 0,
                      $urandom_range(0, 9) != 0,
                      $urandom_range(0, 3) != 0,
                      $urandom_range(0, 3) != 0,
                      $urandom_range(0, 1) == 1,
                      $urandom_range(0, 7) == 0,
                      8'($urandom_range(0, 255)));
      end
      checkOutput();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hc16x_counter.md
Name: hc16x_counter

Overview:
Parametrised synchronous binary/modulo-N up/down counter, the next generation of our 4-bit 74HC161-style counter.
- Keeps the 161 control set: CEP/CET count enables, active-low parallel load PEN and cascadable TC.
- Adds configurable width and modulus, runtime count direction, and a sticky wrap flag.
- Used as a timebase/prescaler and as a cascadable stage in wider counters.

Parameters:
WIDTH, 4, counter width in bits; legal range 2..32.
MODULUS, 16, count sequence is 0..MODULUS-1; legal range 2..2**WIDTH; elaboration error outside this range.
RESET_VALUE, 0, value of Qn after MR; must be < MODULUS.

Ports:
CP  input  1  clock; all state changes on the rising edge.
MR  input  1  master reset; synchronous, active-high.
CEP  input  1  count enable, parallel.
CET  input  1  count enable, trickle; also gates TC.
PEN  input  1  parallel load enable, active-low.
UP  input  1  direction: 1 = count up, 0 = count down.
Dn  input  WIDTH  parallel load data.
OVF_CLR  input  1  clears the OVF flag; synchronous, active-high.
Qn  output  WIDTH  counter state, registered.
TC  output  1  terminal count, combinational.
OVF  output  1  sticky wrap flag, registered.

Behaviour:
Interface
- One clock, CP. Reset MR is synchronous and active-high; it is sampled only on the CP rising edge and has no asynchronous path.

Register update priority at each CP rising edge (highest first)
1. MR=1: Qn <= RESET_VALUE and OVF <= 0. All other inputs are ignored.
2. PEN=0: Qn <= Dn if Dn < MODULUS, otherwise Qn <= MODULUS-1 (clamp).
   - CEP, CET and UP are ignored.
   - OVF is not set by a load.
3. CEP=1 and CET=1: count.
   - Up (UP=1): Qn <= (Qn == MODULUS-1) ? 0 : Qn+1.
   - Down (UP=0): Qn <= (Qn == 0) ? MODULUS-1 : Qn-1.
4. Otherwise: Qn holds.

Terminal count
- Terminal condition: up -> Qn == MODULUS-1; down -> Qn == 0.
- TC = CET & terminal condition. It is combinational and zero-latency, so stages cascade with TC(n) -> CET(n+1).
- TC does not depend on CEP, PEN or MR.
- A change on UP or CET changes TC in the same cycle.

Wrap flag OVF
- A wrap is a count-step edge that takes Qn across the terminal boundary: up MODULUS-1 -> 0, or down 0 -> MODULUS-1.
- OVF <= 1 on any wrap edge.
- Otherwise OVF <= 0 when OVF_CLR=1, else OVF holds.
- Wrap and OVF_CLR on the same edge: set wins, OVF=1.

Arithmetic and boundaries
- Arithmetic is WIDTH-bit unsigned; intermediate results never exceed WIDTH bits.
- When MODULUS == 2**WIDTH, the comparisons reduce to natural binary wrap and the load clamp is never active.
- Direction reversal takes effect on the same edge, e.g. Qn=5 with UP changing 1->0 while counting gives Qn=4 next.
- Reset mid-count: MR beats a simultaneous load and count. OVF is cleared even if that edge would have wrapped.

Reset values
- Qn=RESET_VALUE, OVF=0.
- TC after reset follows the combinational rule: with defaults, UP=1 and CET=1, TC=0.

Latency
- Qn and OVF: 1 cycle from the inputs.
- TC: 0 cycles from Qn, UP and CET.

Test Plan:
1. Defaults. MR=1 for one edge, then PEN=1, CEP=CET=UP=1 for 17 edges -> Qn steps 0,1..15,0,1. TC=1 only while Qn=15. OVF rises on the 15->0 edge and stays 1.
2. MODULUS=10, WIDTH=4.
   - UP=0 from reset 0 -> Qn=9,8,...; TC=1 while Qn=0 before the first edge; OVF=1 after the first edge.
   - Load Dn=13 with PEN=0 -> Qn=9 (clamp); OVF unchanged.
3. Enables. CEP=0 and CET=1 at Qn=15 -> Qn holds, TC=1. CET=0 -> TC=0 and hold. A PEN=0 load with CEP=CET=0 still loads Dn=6.
4. Simultaneous events.
   - MR=1, PEN=0, Dn=7 and a count-enabled wrap, all on one edge -> Qn=0, OVF=0.
   - Wrap plus OVF_CLR=1 on one edge -> OVF=1. OVF_CLR=1 on a non-wrap edge -> OVF=0.
5. Cascade. Two 4-bit instances with TC0 -> CET1 and a shared CEP=1, run 256 edges -> the concatenated {Q1,Q0} increments 0..255 then 0. The high stage OVF sets once, at 255->0.
